prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/cpu_pkg.sv | 14 +
 rtl/prefetch_fifo.sv | 62 ++++++
 rtl/prefetch_queue.sv | 89 ++++++++
 tb/tb_prefetch_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and small helpers for the fetch front end.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 16'h0000;

    // The decoder can retire at most two bytes; the illegal encoding 3 is clipped to 2.
    function automatic logic [1:0] clip_consume(input logic [1:0] c);
        return (c == 2'd3) ? 2'd2 : c;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular byte buffer: one write port, a two-entry read window at the head,
// and a pop of 0..2 bytes per cycle. A flush empties the buffer in one cycle.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [1:0]        pop_i,
    output logic [DATA_W-1:0] rd_data0_o,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [CW-1:0]     count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap for free.
    always_comb begin
        head_d  = head_q + PW'(pop_i);
        tail_d  = tail_q + PW'(wr_en_i);
        count_d = count_q + CW'(wr_en_i) - CW'(pop_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state only; reset discards the contents by clearing the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Byte storage is not reset; entries are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (wr_en_i && !flush_i) begin
            mem_q[tail_q] <= wr_data_i;
        end
    end

    assign rd_data0_o = mem_q[head_q];
    assign rd_data1_o = mem_q[head_q + PW'(1)];
    assign count_o    = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches bytes from a combinational ROM into a
// small FIFO, tracks the PC of the head byte, and handles redirects and
// illegal consume requests.
module prefetch_queue
    import cpu_pkg::*;
#(
    parameter  int                DEPTH        = 4,
    parameter  logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    localparam int                CW           = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic [1:0]        consume,
    output logic [CW-1:0]     q_count,
    output logic [DATA_W-1:0] q_byte0,
    output logic [DATA_W-1:0] q_byte1,
    output logic [ADDR_W-1:0] q_pc,
    output logic              protocol_err
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] q_pc_q, q_pc_d;
    logic              perr_q, perr_d;

    logic [CW-1:0]     count;
    logic [1:0]        want;
    logic [1:0]        eff;
    logic [1:0]        pop;
    logic              fill;

    // Fill/consume arbitration; fullness is judged before this cycle's consume.
    always_comb begin
        want       = clip_consume(consume);
        eff        = (CW'(want) > count) ? 2'(count) : want;
        fill       = 1'b0;
        pop        = 2'd0;
        perr_d     = 1'b0;
        fetch_pc_d = fetch_pc_q;
        q_pc_d     = q_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
            q_pc_d     = redirect_addr;
        end else begin
            fill       = fetch_en && (count < CW'(DEPTH));
            pop        = eff;
            perr_d     = (consume == 2'd3) || (CW'(consume) > count);
            fetch_pc_d = fetch_pc_q + ADDR_W'(fill);
            q_pc_d     = q_pc_q + ADDR_W'(eff);
        end
    end

    // PC and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_VECTOR;
            q_pc_q     <= RESET_VECTOR;
            perr_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_pc_q     <= q_pc_d;
            perr_q     <= perr_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_valid),
        .wr_en_i    (fill),
        .wr_data_i  (rom_data),
        .pop_i      (pop),
        .rd_data0_o (q_byte0),
        .rd_data1_o (q_byte1),
        .count_o    (count)
    );

    assign rom_addr     = fetch_pc_q;
    assign q_count      = count;
    assign q_pc         = q_pc_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios on the reference ROM image,
// then randomized traffic, all compared against a queue-based model.
module tb_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [15:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          fetch_en;
    logic          redirect_valid;
    logic [15:0]   redirect_addr;
    logic [1:0]    consume;
    logic [CW-1:0] q_count;
    logic [7:0]    q_byte0;
    logic [7:0]    q_byte1;
    logic [15:0]   q_pc;
    logic          protocol_err;

    logic [7:0] rom [0:65535];
    assign rom_data = rom[rom_addr];

    prefetch_queue #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .consume        (consume),
        .q_count        (q_count),
        .q_byte0        (q_byte0),
        .q_byte1        (q_byte1),
        .q_pc           (q_pc),
        .protocol_err   (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: byte queue plus the two PCs and the error flag.
    logic [7:0]  mq [$];
    logic [15:0] m_fpc;
    logic [15:0] m_qpc;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = 16'h0000;
        m_qpc = 16'h0000;
        m_err = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        int sz;
        int want;
        int eff;
        bit fill;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (redirect_valid) begin
            mq.delete();
            m_fpc = redirect_addr;
            m_qpc = redirect_addr;
            m_err = 1'b0;
            return;
        end
        sz    = mq.size();
        want  = (consume == 2'd3) ? 2 : int'(consume);
        eff   = (want < sz) ? want : sz;
        fill  = fetch_en && (sz < DEPTH);
        m_err = (consume == 2'd3) || (int'(consume) > sz);
        if (fill) begin
            mq.push_back(rom[m_fpc]);
            m_fpc = m_fpc + 16'd1;
        end
        repeat (eff) void'(mq.pop_front());
        m_qpc = m_qpc + 16'(eff);
    endtask

    task automatic cmp_model(input string ctx);
        check({ctx, ".count"}, 32'(q_count), 32'(mq.size()));
        check({ctx, ".q_pc"}, 32'(q_pc), 32'(m_qpc));
        check({ctx, ".rom_addr"}, 32'(rom_addr), 32'(m_fpc));
        check({ctx, ".perr"}, 32'(protocol_err), 32'(m_err));
        if (mq.size() >= 1) check({ctx, ".byte0"}, 32'(q_byte0), 32'(mq[0]));
        if (mq.size() >= 2) check({ctx, ".byte1"}, 32'(q_byte1), 32'(mq[1]));
    endtask

    task automatic step(input string ctx);
        model_edge();
        @(posedge clk);
        #1;
        cmp_model(ctx);
    endtask

    task automatic drive(input bit fe, input bit rv, input logic [15:0] ra, input logic [1:0] c);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_addr  = ra;
        consume        = c;
    endtask

    logic [7:0] exp_seq [6];

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 8'h00;
        rom[16'h0000] = 8'h01;
        rom[16'h0001] = 8'h00;
        rom[16'h0002] = 8'h16;
        rom[16'h0003] = 8'h48;
        rom[16'h0004] = 8'hFC;
        rom[16'hFFFE] = 8'hAA;
        rom[16'hFFFF] = 8'hBB;

        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 2'd0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cmp_model("reset");

        // Cold start
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 2'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("cold");
            check("cold.count_ramp", 32'(q_count), 32'(i + 1));
        end
        step("cold_hold");
        step("cold_hold");
        check("cold.full", 32'(q_count), 32'd4);
        check("cold.byte0", 32'(q_byte0), 32'h01);
        check("cold.byte1", 32'(q_byte1), 32'h00);
        check("cold.rom_addr", 32'(rom_addr), 32'h0004);

        // Full queue, dual consume: no fill this cycle
        drive(1'b1, 1'b0, 16'h0000, 2'd2);
        step("dual");
        check("dual.count", 32'(q_count), 32'd2);
        check("dual.q_pc", 32'(q_pc), 32'h0002);
        check("dual.byte0", 32'(q_byte0), 32'h16);
        check("dual.byte1", 32'(q_byte1), 32'h48);

        // Redirect overrides a simultaneous consume
        drive(1'b1, 1'b1, 16'h0002, 2'd2);
        step("redir");
        check("redir.count", 32'(q_count), 32'd0);
        check("redir.q_pc", 32'(q_pc), 32'h0002);
        drive(1'b1, 1'b0, 16'h0000, 2'd0);
        step("redir_fill");
        check("redir_fill.count", 32'(q_count), 32'd1);
        check("redir_fill.byte0", 32'(q_byte0), 32'h16);

        // Steady single-byte stream
        drive(1'b1, 1'b1, 16'h0000, 2'd0);
        step("stream_redir");
        drive(1'b1, 1'b0, 16'h0000, 2'd0);
        step("stream_first");
        check("stream.first_byte", 32'(q_byte0), 32'h01);
        exp_seq = '{8'h00, 8'h16, 8'h48, 8'hFC, 8'h00, 8'h00};
        consume = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step("stream");
            check("stream.byte0", 32'(q_byte0), 32'(exp_seq[i]));
            check("stream.q_pc", 32'(q_pc), 32'(i + 1));
            check("stream.count", 32'(q_count), 32'd1);
        end

        // Wrap across FFFF->0000, then an over-consume
        drive(1'b1, 1'b1, 16'hFFFE, 2'd0);
        step("wrap_redir");
        drive(1'b1, 1'b0, 16'h0000, 2'd0);
        repeat (3) step("wrap_fill");
        check("wrap.count", 32'(q_count), 32'd3);
        check("wrap.byte0", 32'(q_byte0), 32'hAA);
        check("wrap.byte1", 32'(q_byte1), 32'hBB);
        drive(1'b0, 1'b0, 16'h0000, 2'd1);
        step("wrap_c1");
        check("wrap.q_pc_ffff", 32'(q_pc), 32'hFFFF);
        step("wrap_c1");
        check("wrap.q_pc_0000", 32'(q_pc), 32'h0000);
        check("wrap.byte0_01", 32'(q_byte0), 32'h01);
        consume = 2'd2;
        step("err");
        check("err.pulse", 32'(protocol_err), 32'd1);
        check("err.count", 32'(q_count), 32'd0);
        consume = 2'd0;
        step("err_clear");
        check("err.clear", 32'(protocol_err), 32'd0);

        // Asynchronous reset between clock edges
        drive(1'b1, 1'b1, 16'h0010, 2'd0);
        step("ar_redir");
        drive(1'b1, 1'b0, 16'h0000, 2'd0);
        repeat (3) step("ar_fill");
        check("ar.pre_count", 32'(q_count), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("ar.count", 32'(q_count), 32'd0);
        check("ar.rom_addr", 32'(rom_addr), 32'h0000);
        check("ar.q_pc", 32'(q_pc), 32'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("ar_refill");
        check("ar.refill_byte0", 32'(q_byte0), 32'h01);

        // Randomized traffic over a scratch region and the top-of-memory wrap
        for (int a = 16'h2000; a < 16'h2200; a++) rom[a] = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 99);
            c = $urandom_range(0, 9);
            redirect_valid = (r < 6);
            redirect_addr  = (r < 2) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                     : 16'h2000 + 16'($urandom_range(0, 255));
            fetch_en       = ($urandom_range(0, 3) != 0);
            consume        = (c < 3) ? 2'd0 : (c < 6) ? 2'd1 : (c < 9) ? 2'd2 : 2'd3;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
